regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32x32 MIPS register file between two requesters.
  - Port A: main pipeline writeback.
  - Port B: a multi-cycle unit such as mult/div or an uncached load.
- Uses fixed priority to A, with a starvation guard for B.
- Keeps a 32-bit pending scoreboard of B destinations, so decode can detect RAW and WAW hazards against in-flight multi-cycle results.
- Sits between writeback/multi-cycle units and the register file's WriteRegister/WriteData/RegWrite inputs.

---
 rtl/regfile_write_arbiter_pkg.sv | 7 +
 rtl/regfile_scoreboard.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 77 +++++++
 tb/tb_regfile_write_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg: register file geometry shared with the register file itself
package regfile_write_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits for in-flight multi-cycle results
module regfile_scoreboard
    import regfile_write_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_reg,
    output logic                  issue_ready,
    input  logic                  clr_valid,
    input  logic [REG_ADDR_W-1:0] clr_reg,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic                  rs_pending,
    output logic                  rt_pending
);
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_nxt;
    logic                set_en;

    assign issue_ready = !pend[issue_reg] || (clr_valid && clr_reg == issue_reg);
    assign set_en      = issue_valid && issue_ready && issue_reg != REG_ZERO;
    assign rs_pending  = pend[rs_addr];
    assign rt_pending  = pend[rt_addr];

    // clear on completing write, then set on issue so a same-register reissue wins
    always_comb begin
        pend_nxt = pend;
        if (clr_valid) pend_nxt[clr_reg] = 1'b0;
        if (set_en) pend_nxt[issue_reg] = 1'b1;
    end

    // pending vector; bit 0 is never set so $zero always reads as free
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend <= '0;
        else pend <= pend_nxt;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register file write port between pipeline (A) and multi-cycle unit (B)
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    input  logic [REG_ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_reg,
    output logic                  issue_ready,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    output logic                  rs_pending,
    output logic                  rt_pending,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_wr,
    output logic [DATA_W-1:0]     rf_wd
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt;
    logic             force_b;

    assign force_b = b_valid && wait_cnt == LIMIT;
    assign a_ready = a_valid && !force_b;
    assign b_ready = b_valid && !a_ready;

    // registered write port; unused cycles drop rf_we but keep address/data stable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we <= 1'b0;
            rf_wr <= REG_ZERO;
            rf_wd <= '0;
        end else if (a_ready) begin
            rf_we <= a_reg != REG_ZERO;
            rf_wr <= a_reg;
            rf_wd <= a_data;
        end else if (b_ready) begin
            rf_we <= b_reg != REG_ZERO;
            rf_wr <= b_reg;
            rf_wd <= b_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // count consecutive cycles B is kept waiting, saturating at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_cnt <= '0;
        else if (!b_valid || b_ready) wait_cnt <= '0;
        else if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + CNT_W'(1);
    end

    regfile_scoreboard u_sb (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_reg  (issue_reg),
        .issue_ready(issue_ready),
        .clr_valid  (b_ready),
        .clr_reg    (b_reg),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_pending (rs_pending),
        .rt_pending (rt_pending)
    );
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scenario tasks plus randomized traffic against a behavioural model
module tb_regfile_write_arbiter;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  a_reg = '0, b_reg = '0, issue_reg = '0, rs_addr = '0, rt_addr = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, issue_ready, rs_pending, rt_pending, rf_we;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int          m_wait;
    bit          m_pend [32];
    bit          m_we;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    bit          e_a, e_b, e_issue;
    logic [31:0] rf_mem [32];

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_reg(issue_reg), .issue_ready(issue_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_pending(rs_pending), .rt_pending(rt_pending),
        .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    // register file consumer committing one edge after the arbiter output
    always @(posedge clk) if (rf_we && rf_wr != 5'd0) rf_mem[rf_wr] <= rf_wd;

    task automatic model_reset();
        m_wait = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_we = 1'b0;
        m_wr = '0;
        m_wd = '0;
    endtask

    // grants: A wins unless B has waited the limit; B takes whatever A leaves
    task automatic model_comb();
        e_a = a_valid && !(b_valid && m_wait == LIMIT);
        e_b = b_valid && !e_a;
        e_issue = issue_reg == 5'd0 || !m_pend[issue_reg] || (e_b && b_reg == issue_reg);
    endtask

    task automatic tick();
        bit          n_we;
        logic [4:0]  n_wr;
        logic [31:0] n_wd;
        int          n_wait;
        model_comb();
        n_we = 1'b0;
        n_wr = m_wr;
        n_wd = m_wd;
        if (e_a) begin
            n_we = a_reg != 0; n_wr = a_reg; n_wd = a_data;
        end else if (e_b) begin
            n_we = b_reg != 0; n_wr = b_reg; n_wd = b_data;
        end
        n_wait = (b_valid && !e_b) ? ((m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1) : 0;
        @(posedge clk);
        #1;
        if (e_b) m_pend[b_reg] = 1'b0;
        if (issue_valid && e_issue && issue_reg != 0) m_pend[issue_reg] = 1'b1;
        m_we = n_we; m_wr = n_wr; m_wd = n_wd; m_wait = n_wait;
    endtask

    task automatic idle();
        a_valid = 0; b_valid = 0; issue_valid = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rs_addr = 5'd3; rt_addr = 5'd9; issue_reg = 5'd3;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", rf_we); end
        checks++; if (rf_wr !== 5'd0) begin errors++; $display("FAIL reset_wr: got %0d want 0", rf_wr); end
        checks++; if (rf_wd !== 32'd0) begin errors++; $display("FAIL reset_wd: got %h want 0", rf_wd); end
        checks++; if (rs_pending !== 1'b0 || rt_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b%b want 00", rs_pending, rt_pending); end
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %b want 1", issue_ready); end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_a_only();
        a_valid = 1; a_reg = 5'd5; a_data = 32'hFFFF_FFFF;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready: got %b want 1", a_ready); end
        tick();
        idle();
        checks++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd5, 32'hFFFF_FFFF}) begin errors++; $display("FAIL a_only_write: got we=%b wr=%0d wd=%h want we=1 wr=5 wd=ffffffff", rf_we, rf_wr, rf_wd); end
        tick();
        checks++; if (rf_mem[5] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL a_only_commit: got %h want ffffffff", rf_mem[5]); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL a_only_idle_we: got %b want 0", rf_we); end
    endtask

    task automatic test_contention();
        for (int i = 0; i < 6; i++) begin
            a_valid = 1; a_reg = 5'd10 + 5'(i); a_data = 32'h1000 + i;
            b_valid = 1; b_reg = 5'd20; b_data = 32'hB0B0_0000 + i;
            #1;
            model_comb();
            checks++; if (a_ready !== (i != 4) || b_ready !== (i == 4)) begin errors++; $display("FAIL contention_grant cyc%0d: got a=%b b=%b want a=%b b=%b", i, a_ready, b_ready, i != 4, i == 4); end
            checks++; if (a_ready !== e_a || b_ready !== e_b) begin errors++; $display("FAIL contention_model cyc%0d: got a=%b b=%b want a=%b b=%b", i, a_ready, b_ready, e_a, e_b); end
            tick();
            if (i == 4) begin
                checks++; if (dut.wait_cnt !== 4'd0) begin errors++; $display("FAIL contention_wait_clear: got %0d want 0", dut.wait_cnt); end
                checks++; if (rf_wd !== 32'hB0B0_0004 || rf_wr !== 5'd20) begin errors++; $display("FAIL contention_b_write: got wr=%0d wd=%h want wr=20 wd=b0b00004", rf_wr, rf_wd); end
            end
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_reg = 5'd2;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL sb_first_issue: got %b want 1", issue_ready); end
        tick();
        rs_addr = 5'd2;
        #1;
        checks++; if (rs_pending !== 1'b1) begin errors++; $display("FAIL sb_rs_pending: got %b want 1", rs_pending); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL sb_waw_block: got %b want 0", issue_ready); end
        tick();
        issue_valid = 0;
        b_valid = 1; b_reg = 5'd2; b_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL sb_b_ready: got %b want 1", b_ready); end
        tick();
        idle();
        #1;
        checks++; if (rs_pending !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b want 0", rs_pending); end
        checks++; if (rf_we !== 1'b1 || rf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sb_b_data: got we=%b wd=%h want we=1 wd=deadbeef", rf_we, rf_wd); end
    endtask

    task automatic test_same_edge();
        issue_valid = 1; issue_reg = 5'd7;
        tick();
        b_valid = 1; b_reg = 5'd7; b_data = 32'h7777_0007;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL same_edge_ready: got %b want 1", issue_ready); end
        tick();
        idle();
        rt_addr = 5'd7;
        #1;
        checks++; if (rt_pending !== 1'b1) begin errors++; $display("FAIL same_edge_pending: got %b want 1", rt_pending); end
        b_valid = 1;
        tick();
        idle();
        #1;
        checks++; if (rt_pending !== 1'b0) begin errors++; $display("FAIL same_edge_cleanup: got %b want 0", rt_pending); end
    endtask

    task automatic test_zero();
        a_valid = 1; a_reg = 5'd0; a_data = 32'h1234_5678;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL zero_a_ready: got %b want 1", a_ready); end
        tick();
        idle();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL zero_we: got %b want 0", rf_we); end
        issue_valid = 1; issue_reg = 5'd0;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL zero_issue_ready: got %b want 1", issue_ready); end
        tick();
        idle();
        rs_addr = 5'd0;
        #1;
        checks++; if (rs_pending !== 1'b0) begin errors++; $display("FAIL zero_pending: got %b want 0", rs_pending); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            a_valid = 1'($urandom_range(0, 1));
            b_valid = 1'($urandom_range(0, 2) != 0);
            issue_valid = 1'($urandom_range(0, 1));
            a_reg = 5'($urandom_range(0, 7));
            b_reg = 5'($urandom_range(0, 7));
            issue_reg = 5'($urandom_range(0, 7));
            rs_addr = 5'($urandom_range(0, 7));
            rt_addr = 5'($urandom_range(0, 7));
            a_data = $urandom;
            b_data = $urandom;
            #1;
            model_comb();
            checks++; if ({a_ready, b_ready, issue_ready} !== {e_a, e_b, e_issue}) begin errors++; $display("FAIL rnd_grant n=%0d: got a=%b b=%b i=%b want a=%b b=%b i=%b", n, a_ready, b_ready, issue_ready, e_a, e_b, e_issue); end
            checks++; if (rs_pending !== m_pend[rs_addr] || rt_pending !== m_pend[rt_addr]) begin errors++; $display("FAIL rnd_pending n=%0d: got %b%b want %b%b", n, rs_pending, rt_pending, m_pend[rs_addr], m_pend[rt_addr]); end
            tick();
            checks++; if ({rf_we, rf_wr, rf_wd} !== {m_we, m_wr, m_wd}) begin errors++; $display("FAIL rnd_write n=%0d: got we=%b wr=%0d wd=%h want we=%b wr=%0d wd=%h", n, rf_we, rf_wr, rf_wd, m_we, m_wr, m_wd); end
        end
        idle();
        tick();
    endtask

    task automatic test_async_reset();
        issue_valid = 1; issue_reg = 5'd9;
        b_valid = 1; b_reg = 5'd9;
        repeat (2) tick();
        idle();
        a_valid = 1; a_reg = 5'd3; a_data = 32'hCAFE_0003;
        issue_valid = 1; issue_reg = 5'd9;
        tick();
        idle();
        rt_addr = 5'd9;
        #1;
        checks++; if (rf_we !== 1'b1 || rt_pending !== 1'b1) begin errors++; $display("FAIL async_pre: got we=%b pend=%b want 1 1", rf_we, rt_pending); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL async_we: got %b want 0", rf_we); end
        checks++; if (rt_pending !== 1'b0) begin errors++; $display("FAIL async_pending: got %b want 0", rt_pending); end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_contention();
        test_scoreboard();
        test_same_edge();
        test_zero();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
